// File: rtl/hci_core_mux_dynamic_lat_pkg.sv
// Shared types and width helpers for the dynamic-latency HCI core mux.
package hci_core_mux_dynamic_lat_pkg;

    typedef enum logic {HCI_ARB_RR = 1'b0, HCI_ARB_FIXED = 1'b1} hci_arb_mode_t;

    localparam int unsigned HCI_DW = 32;
    localparam int unsigned HCI_AW = 32;
    localparam int unsigned HCI_BW = 8;
    localparam int unsigned HCI_WW = 32;
    localparam int unsigned HCI_OW = 1;
    localparam int unsigned HCI_UW = 2;

    // Index width for n candidates; a single candidate still needs one bit of storage.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned boffs_width(input int unsigned dw, input int unsigned bw,
                                                input int unsigned ww);
        int unsigned w;
        w = (dw / ww) * $clog2(ww / bw);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/hci_core_mux_idx_fifo.sv
// Small synchronous FIFO holding arbitration winners until their responses return.
module hci_core_mux_idx_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (r_count == CW'(DEPTH));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= wrap_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= wrap_inc(r_rd_ptr);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/hci_core_mux_dynamic_lat.sv
// Funnels NB_IN_CHAN HCI core channels onto NB_OUT_CHAN outputs; each output arbitrates
// its statically bound inputs and remembers winners so in-order responses route back.
module hci_core_mux_dynamic_lat
    import hci_core_mux_dynamic_lat_pkg::*;
#(
    parameter int unsigned   NB_IN_CHAN  = 4,
    parameter int unsigned   NB_OUT_CHAN = 2,
    parameter int unsigned   DW          = HCI_DW,
    parameter int unsigned   AW          = HCI_AW,
    parameter int unsigned   BW          = HCI_BW,
    parameter int unsigned   WW          = HCI_WW,
    parameter int unsigned   OW          = HCI_OW,
    parameter int unsigned   UW          = HCI_UW,
    parameter int unsigned   MAX_OUTST   = 4,
    parameter hci_arb_mode_t ARB_MODE    = HCI_ARB_RR,
    localparam int unsigned  BEW         = DW / BW,
    localparam int unsigned  OFW         = boffs_width(DW, BW, WW),
    localparam int unsigned  CW          = $clog2(MAX_OUTST + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,
    input  logic [NB_IN_CHAN-1:0]                 in_req_i,
    output logic [NB_IN_CHAN-1:0]                 in_gnt_o,
    input  logic [NB_IN_CHAN-1:0][AW-1:0]         in_add_i,
    input  logic [NB_IN_CHAN-1:0]                 in_wen_i,
    input  logic [NB_IN_CHAN-1:0][BEW-1:0]        in_be_i,
    input  logic [NB_IN_CHAN-1:0][DW-1:0]         in_data_i,
    input  logic [NB_IN_CHAN-1:0][OFW-1:0]        in_boffs_i,
    input  logic [NB_IN_CHAN-1:0][UW-1:0]         in_user_i,
    input  logic [NB_IN_CHAN-1:0]                 in_lrdy_i,
    output logic [NB_IN_CHAN-1:0][DW-1:0]         in_r_data_o,
    output logic [NB_IN_CHAN-1:0]                 in_r_valid_o,
    output logic [NB_IN_CHAN-1:0][OW-1:0]         in_r_opc_o,
    output logic [NB_IN_CHAN-1:0][UW-1:0]         in_r_user_o,
    output logic [NB_OUT_CHAN-1:0]                out_req_o,
    input  logic [NB_OUT_CHAN-1:0]                out_gnt_i,
    output logic [NB_OUT_CHAN-1:0][AW-1:0]        out_add_o,
    output logic [NB_OUT_CHAN-1:0]                out_wen_o,
    output logic [NB_OUT_CHAN-1:0][BEW-1:0]       out_be_o,
    output logic [NB_OUT_CHAN-1:0][DW-1:0]        out_data_o,
    output logic [NB_OUT_CHAN-1:0][OFW-1:0]       out_boffs_o,
    output logic [NB_OUT_CHAN-1:0][UW-1:0]        out_user_o,
    output logic [NB_OUT_CHAN-1:0]                out_lrdy_o,
    input  logic [NB_OUT_CHAN-1:0][DW-1:0]        out_r_data_i,
    input  logic [NB_OUT_CHAN-1:0]                out_r_valid_i,
    input  logic [NB_OUT_CHAN-1:0][OW-1:0]        out_r_opc_i,
    input  logic [NB_OUT_CHAN-1:0][UW-1:0]        out_r_user_i,
    output logic [NB_OUT_CHAN-1:0][CW-1:0]        outst_o,
    output logic                                  err_o
);

    localparam int unsigned K   = NB_IN_CHAN / NB_OUT_CHAN;
    localparam int unsigned IW  = idx_width(K);
    localparam int unsigned RQW = AW + 1 + BEW + DW + OFW + UW + 1;

    logic                   w_srst;
    logic [NB_OUT_CHAN-1:0] w_err_set;
    logic                   r_err;

    assign w_srst = rst_i | clear_i;
    assign err_o  = r_err;

    for (genvar gi = 0; gi < NB_OUT_CHAN; gi++) begin : g_out
        logic [K-1:0]          w_cand_req;
        logic [K-1:0][RQW-1:0] w_cand_pl;
        logic [IW-1:0]         w_win;
        logic [IW-1:0]         w_head;
        logic [IW-1:0]         r_ptr;
        logic                  w_any;
        logic                  w_full;
        logic                  w_empty;
        logic                  w_hs;
        logic                  w_rv;
        logic                  w_pop;

        for (genvar gk = 0; gk < K; gk++) begin : g_cand
            localparam int unsigned J = gk * NB_OUT_CHAN + gi;
            assign w_cand_req[gk]  = in_req_i[J];
            assign w_cand_pl[gk]   = {in_add_i[J], in_wen_i[J], in_be_i[J], in_data_i[J],
                                      in_boffs_i[J], in_user_i[J], in_lrdy_i[J]};
            assign in_gnt_o[J]     = out_gnt_i[gi] & out_req_o[gi] & (w_win == IW'(gk));
            assign in_r_valid_o[J] = w_pop & (w_head == IW'(gk));
            assign in_r_data_o[J]  = in_r_valid_o[J] ? out_r_data_i[gi] : '0;
            assign in_r_opc_o[J]   = in_r_valid_o[J] ? out_r_opc_i[gi]  : '0;
            assign in_r_user_o[J]  = in_r_valid_o[J] ? out_r_user_i[gi] : '0;
        end

        // Scan offsets from farthest to nearest so the candidate closest to the start wins.
        always_comb begin
            int c;
            w_win = '0;
            for (int s = K - 1; s >= 0; s--) begin
                c = (ARB_MODE == HCI_ARB_RR) ? (int'(r_ptr) + s) % int'(K) : s;
                if (w_cand_req[c]) w_win = IW'(c);
            end
        end

        assign w_any          = |w_cand_req;
        assign out_req_o[gi]  = w_any & ~w_full & ~w_srst;
        assign w_hs           = out_req_o[gi] & out_gnt_i[gi];
        assign {out_add_o[gi], out_wen_o[gi], out_be_o[gi], out_data_o[gi],
                out_boffs_o[gi], out_user_o[gi], out_lrdy_o[gi]} = w_cand_pl[w_win];

        assign w_rv          = out_r_valid_i[gi] & ~w_srst;
        assign w_pop         = w_rv & ~w_empty;
        assign w_err_set[gi] = w_rv & w_empty;

        always_ff @(posedge clk_i) begin
            if (w_srst) begin
                r_ptr <= '0;
            end else if (w_hs && ARB_MODE == HCI_ARB_RR) begin
                r_ptr <= (w_win == IW'(K - 1)) ? '0 : w_win + 1'b1;
            end
        end

        hci_core_mux_idx_fifo #(
            .WIDTH (IW),
            .DEPTH (MAX_OUTST)
        ) u_idx_fifo (
            .clk_i   (clk_i),
            .rst_i   (w_srst),
            .push_i  (w_hs),
            .data_i  (w_win),
            .pop_i   (w_pop),
            .data_o  (w_head),
            .full_o  (w_full),
            .empty_o (w_empty),
            .count_o (outst_o[gi])
        );
    end

    always_ff @(posedge clk_i) begin
        if (w_srst) begin
            r_err <= 1'b0;
        end else if (|w_err_set) begin
            r_err <= 1'b1;
        end
    end

endmodule
